// File: rtl/gpr_wbq.sv
// Writeback queue in front of the register file, with optional operand forwarding.
// Define GPR_WBQ_FWD_EN to build the rs/rt forwarding comparators; otherwise the fwd outputs are tied to 0.
module gpr_wbq #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [4:0]  wb_num,
    input  logic [31:0] wb_data,
    output logic        reg_write,
    output logic [4:0]  num_write,
    output logic [31:0] data_write,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        fwd_a_hit,
    output logic [31:0] fwd_a,
    output logic        fwd_b_hit,
    output logic [31:0] fwd_b,
    output logic        idle
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    num_mem  [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    // Writes to r0 are swallowed at the input so they never occupy a slot.
    assign wb_ready = (count != CW'(DEPTH));
    assign push     = wb_valid && wb_ready && (wb_num != 5'd0);
    assign pop      = (count != '0);
    assign idle     = (count == '0);

    assign reg_write  = pop;
    assign num_write  = pop ? num_mem[rd_ptr]  : 5'd0;
    assign data_write = pop ? data_mem[rd_ptr] : 32'd0;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                num_mem[wr_ptr]  <= wb_num;
                data_mem[wr_ptr] <= wb_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef GPR_WBQ_FWD_EN
    logic [AW-1:0] slot;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        fwd_a_hit = 1'b0;
        fwd_a     = 32'd0;
        fwd_b_hit = 1'b0;
        fwd_b     = 32'd0;
        slot      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = rd_ptr + AW'(k);
            if (CW'(k) < count) begin
                if ((rs != 5'd0) && (num_mem[slot] == rs)) begin
                    fwd_a_hit = 1'b1;
                    fwd_a     = data_mem[slot];
                end
                if ((rt != 5'd0) && (num_mem[slot] == rt)) begin
                    fwd_b_hit = 1'b1;
                    fwd_b     = data_mem[slot];
                end
            end
        end
    end
`else
    logic unused_query;

    assign unused_query = ^{rs, rt};
    assign fwd_a_hit    = 1'b0;
    assign fwd_a        = 32'd0;
    assign fwd_b_hit    = 1'b0;
    assign fwd_b        = 32'd0;
`endif

endmodule

// File: tb/tb_gpr_wbq.sv
// Self-checking bench for gpr_wbq: directed vector table, hand-written sequences and a
// random phase, all scored against a queue model of the pending writebacks.
module tb_gpr_wbq;

    localparam int DEPTH = 4;
`ifdef GPR_WBQ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_num;
    logic [31:0] wb_data;
    logic        reg_write;
    logic [4:0]  num_write;
    logic [31:0] data_write;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        fwd_a_hit;
    logic [31:0] fwd_a;
    logic        fwd_b_hit;
    logic [31:0] fwd_b;
    logic        idle;

    gpr_wbq #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_num(wb_num), .wb_data(wb_data),
        .reg_write(reg_write), .num_write(num_write), .data_write(data_write),
        .rs(rs), .rt(rt),
        .fwd_a_hit(fwd_a_hit), .fwd_a(fwd_a), .fwd_b_hit(fwd_b_hit), .fwd_b(fwd_b),
        .idle(idle)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  num;
        logic [31:0] data;
    } entry_t;

    typedef struct {
        logic        v;
        logic [4:0]  num;
        logic [31:0] data;
        logic [4:0]  qa;
        logic [4:0]  qb;
        logic        e_rw;
        logic [4:0]  e_num;
        logic [31:0] e_data;
        logic        e_fa_hit;
        logic [31:0] e_fa;
        logic        e_fb_hit;
        logic [31:0] e_fb;
    } vec_t;

    entry_t sb_q[$];
    vec_t   vecs[12];
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; outputs settle 1 time unit later.
    task automatic applyStimulus(input logic v, input logic [4:0] num, input logic [31:0] data,
                                 input logic [4:0] qa, input logic [4:0] qb, input logic rst_n);
        @(negedge clock);
        wb_valid = v;
        wb_num   = num;
        wb_data  = data;
        rs       = qa;
        rt       = qb;
        reset_n  = rst_n;
        #1;
    endtask

    // Compare every output against the scoreboard queue as it stands before the next edge.
    task automatic checkOutput();
        logic        e_fa_hit = 1'b0;
        logic        e_fb_hit = 1'b0;
        logic [31:0] e_fa     = 32'd0;
        logic [31:0] e_fb     = 32'd0;
        logic        e_rw     = (sb_q.size() != 0);
        foreach (sb_q[i]) begin
            if (rs != 5'd0 && sb_q[i].num == rs) begin
                e_fa_hit = 1'b1;
                e_fa     = sb_q[i].data;
            end
            if (rt != 5'd0 && sb_q[i].num == rt) begin
                e_fb_hit = 1'b1;
                e_fb     = sb_q[i].data;
            end
        end
        check("reg_write", 32'(reg_write), 32'(e_rw));
        check("idle", 32'(idle), 32'(!e_rw));
        check("wb_ready", 32'(wb_ready), 32'(sb_q.size() != DEPTH));
        check("num_write", 32'(num_write), e_rw ? 32'(sb_q[0].num) : 32'd0);
        check("data_write", data_write, e_rw ? sb_q[0].data : 32'd0);
        check("fwd_a_hit", 32'(fwd_a_hit), 32'(e_fa_hit && FWD));
        check("fwd_a", fwd_a, FWD ? e_fa : 32'd0);
        check("fwd_b_hit", 32'(fwd_b_hit), 32'(e_fb_hit && FWD));
        check("fwd_b", fwd_b, FWD ? e_fb : 32'd0);
    endtask

    // Advance through the rising edge and update the scoreboard the way the queue should.
    task automatic finishEdge();
        logic ready_before = (sb_q.size() != DEPTH);
        @(posedge clock);
        if (!reset_n) begin
            sb_q.delete();
        end else begin
            if (sb_q.size() != 0) begin
                void'(sb_q.pop_front());
            end
            if (wb_valid && ready_before && wb_num != 5'd0) begin
                sb_q.push_back('{num: wb_num, data: wb_data});
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [4:0] num, input logic [31:0] data,
                         input logic [4:0] qa, input logic [4:0] qb, input logic rst_n);
        applyStimulus(v, num, data, qa, qb, rst_n);
        checkOutput();
        finishEdge();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Expected outputs for the cycle in which each row's inputs are presented.
        vecs[0]  = '{1'b1, 5'd5, 32'h1234,      5'd5, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,         5'd5, 5'd0, 1'b1, 5'd5, 32'h1234, 1'b1, 32'h1234, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0};
        vecs[4]  = '{1'b1, 5'd7, 32'h11,        5'd7, 5'd3, 1'b0, 5'd0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0};
        vecs[5]  = '{1'b1, 5'd7, 32'h22,        5'd7, 5'd3, 1'b1, 5'd7, 32'h11,   1'b1, 32'h11,   1'b0, 32'h0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,         5'd7, 5'd3, 1'b1, 5'd7, 32'h22,   1'b1, 32'h22,   1'b0, 32'h0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,         5'd7, 5'd7, 1'b0, 5'd0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0};
        vecs[8]  = '{1'b1, 5'd3, 32'h33,        5'd3, 5'd3, 1'b0, 5'd0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0};
        vecs[9]  = '{1'b1, 5'd9, 32'h99,        5'd3, 5'd9, 1'b1, 5'd3, 32'h33,   1'b1, 32'h33,   1'b0, 32'h0};
        vecs[10] = '{1'b0, 5'd0, 32'h0,         5'd9, 5'd3, 1'b1, 5'd9, 32'h99,   1'b1, 32'h99,   1'b0, 32'h0};
        vecs[11] = '{1'b0, 5'd0, 32'h0,         5'd9, 5'd3, 1'b0, 5'd0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0};

        wb_valid = 1'b0;
        wb_num   = 5'd0;
        wb_data  = 32'd0;
        rs       = 5'd0;
        rt       = 5'd0;
        reset_n  = 1'b0;
        repeat (2) @(posedge clock);
        sb_q.delete();

        $display("[TB] reset state");
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);
        check("reset reg_write", 32'(reg_write), 32'd0);
        check("reset idle", 32'(idle), 32'd1);
        check("reset wb_ready", 32'(wb_ready), 32'd1);
        checkOutput();
        finishEdge();

        $display("[TB] vector table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].v, vecs[i].num, vecs[i].data, vecs[i].qa, vecs[i].qb, 1'b1);
            check($sformatf("vec%0d reg_write", i), 32'(reg_write), 32'(vecs[i].e_rw));
            check($sformatf("vec%0d num_write", i), 32'(num_write), 32'(vecs[i].e_num));
            check($sformatf("vec%0d data_write", i), data_write, vecs[i].e_data);
            check($sformatf("vec%0d idle", i), 32'(idle), 32'(!vecs[i].e_rw));
            check($sformatf("vec%0d fwd_a_hit", i), 32'(fwd_a_hit), 32'(vecs[i].e_fa_hit && FWD));
            check($sformatf("vec%0d fwd_a", i), fwd_a, FWD ? vecs[i].e_fa : 32'd0);
            check($sformatf("vec%0d fwd_b_hit", i), 32'(fwd_b_hit), 32'(vecs[i].e_fb_hit && FWD));
            check($sformatf("vec%0d fwd_b", i), fwd_b, FWD ? vecs[i].e_fb : 32'd0);
            checkOutput();
            finishEdge();
        end

        $display("[TB] back-to-back fill then wrap");
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 5'(i), 32'hA0 + 32'(i), 5'(i), 5'd1, 1'b1);
        end
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 5'(i + 10), 32'h100 + 32'(i), 5'(i + 9), 5'(i + 10), 1'b1);
        end
        repeat (2) cycle(1'b0, 5'd0, 32'd0, 5'd20, 5'd0, 1'b1);

        $display("[TB] reset mid-drain");
        cycle(1'b1, 5'd12, 32'hAA, 5'd0, 5'd0, 1'b1);
        cycle(1'b1, 5'd13, 32'hBB, 5'd13, 5'd12, 1'b1);
        cycle(1'b1, 5'd14, 32'hCC, 5'd13, 5'd14, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd13, 5'd14, 1'b1);
        check("post-reset reg_write", 32'(reg_write), 32'd0);
        check("post-reset idle", 32'(idle), 32'd1);
        check("post-reset wb_ready", 32'(wb_ready), 32'd1);
        checkOutput();
        finishEdge();
        repeat (3) cycle(1'b0, 5'd0, 32'd0, 5'd13, 5'd14, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 200; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom(),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 40) != 0));
        end
        repeat (3) cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
